// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative signed divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_STEPS = 32;
    localparam int DIV_CNT_W = $clog2(DIV_STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between the execute stage and the sequential divider.
interface seq_divider_if;
    import div_pkg::*;

    logic                 start;
    logic [DIV_WIDTH-1:0] dividend;
    logic [DIV_WIDTH-1:0] divisor;
    logic [DIV_WIDTH-1:0] quotient;
    logic [DIV_WIDTH-1:0] remainder;
    logic                 ready;
    logic                 exception;
    logic                 busy;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, ready, exception, busy
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, ready, exception, busy
    );

endinterface

// File: rtl/twos_negate.sv
// Two's-complement negation: invert, then add one.
module twos_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] inv;

    assign inv = ~a;
    assign y   = inv + {{(WIDTH-1){1'b0}}, 1'b1};

endmodule

// File: rtl/seq_divider.sv
// Restoring signed divider: one quotient bit per cycle on operand magnitudes,
// then a sign-fix cycle before the result is published with a one-cycle ready.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input logic          clock,
    input logic          reset_n,
    seq_divider_if.slave bus
);

    div_state_e           state;
    logic [DIV_CNT_W-1:0] count;
    logic                 neg_q;
    logic                 neg_r;
    logic                 zero;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     dvs;
    logic [WIDTH-1:0]     q_res;
    logic [WIDTH-1:0]     r_res;
    logic [WIDTH-1:0]     quotient_r;
    logic [WIDTH-1:0]     remainder_r;
    logic                 ready_r;
    logic                 exception_r;
    logic                 busy_r;

    logic [WIDTH-1:0]     neg_dividend;
    logic [WIDTH-1:0]     shared_in;
    logic [WIDTH-1:0]     neg_shared;
    logic [WIDTH-1:0]     neg_rem;
    logic [WIDTH-1:0]     dividend_mag;
    logic [WIDTH-1:0]     divisor_mag;
    logic [WIDTH-1:0]     rem_shift;
    logic [WIDTH:0]       trial;

    twos_negate #(.WIDTH(WIDTH)) u_neg_op (.a(bus.dividend), .y(neg_dividend));

    // The quotient fixer is idle whenever a request is accepted, so it doubles as the
    // divisor negator; an accepted start discards any FIX in flight anyway.
    assign shared_in = bus.start ? bus.divisor : quo;

    twos_negate #(.WIDTH(WIDTH)) u_neg_q (.a(shared_in), .y(neg_shared));
    twos_negate #(.WIDTH(WIDTH)) u_neg_r (.a(rem), .y(neg_rem));

    assign dividend_mag = bus.dividend[WIDTH-1] ? neg_dividend : bus.dividend;
    assign divisor_mag  = bus.divisor[WIDTH-1] ? neg_shared : bus.divisor;

    // Trial subtract as an add of the inverted divisor; bit WIDTH is the no-borrow carry.
    assign rem_shift = {rem[WIDTH-2:0], quo[WIDTH-1]};
    assign trial     = {1'b0, rem_shift} + {1'b0, ~dvs} + {{WIDTH{1'b0}}, 1'b1};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            count       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero        <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            q_res       <= '0;
            r_res       <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            ready_r     <= 1'b0;
            exception_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            ready_r <= 1'b0;
            if (bus.start) begin
                neg_q  <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                neg_r  <= bus.dividend[WIDTH-1];
                quo    <= dividend_mag;
                dvs    <= divisor_mag;
                rem    <= '0;
                count  <= '0;
                q_res  <= '0;
                r_res  <= '0;
                zero   <= (bus.divisor == '0);
                busy_r <= 1'b1;
                state  <= (bus.divisor == '0) ? DONE : RUN;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    RUN: begin
                        rem   <= trial[WIDTH] ? trial[WIDTH-1:0] : rem_shift;
                        quo   <= {quo[WIDTH-2:0], trial[WIDTH]};
                        count <= count + DIV_CNT_W'(1);
                        if (count == DIV_CNT_W'(DIV_STEPS - 1)) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        q_res <= neg_q ? neg_shared : quo;
                        r_res <= neg_r ? neg_rem : rem;
                        state <= DONE;
                    end
                    DONE: begin
                        quotient_r  <= q_res;
                        remainder_r <= r_res;
                        exception_r <= zero;
                        ready_r     <= 1'b1;
                        busy_r      <= 1'b0;
                        state       <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.ready     = ready_r;
    assign bus.exception = exception_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table plus restart and reset sequences.
module tb_seq_divider;
    import div_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        exc;
        int          lat;
        int          busy_cycles;
    } vec_t;

    logic clock = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    seq_divider_if bus ();

    seq_divider dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one request and waits (bounded) for ready; reports latency and busy cycles.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           output int lat, output int busy_cnt, output logic busy_at_ready);
        @(negedge clock);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clock);
        #1;
        bus.start     = 1'b0;
        lat           = -1;
        busy_cnt      = 0;
        busy_at_ready = 1'bx;
        if (bus.busy) busy_cnt++;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clock);
            #1;
            if (bus.ready) begin
                lat           = i;
                busy_at_ready = bus.busy;
                break;
            end
            if (bus.busy) busy_cnt++;
        end
    endtask

    vec_t        vecs[14];
    int          lat;
    int          bcnt;
    int          rdy;
    logic        bar;
    logic [31:0] got_q;
    logic [31:0] got_r;

    initial begin
        vecs[0]  = '{32'd100,      32'd7,          32'd14,         32'd2,          1'b0, 34, 34};
        vecs[1]  = '{-32'sd100,    32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 34, 34};
        vecs[2]  = '{32'd100,      -32'sd7,        32'hFFFFFFF2,   32'd2,          1'b0, 34, 34};
        vecs[3]  = '{-32'sd100,    -32'sd7,        32'd14,         32'hFFFFFFFE,   1'b0, 34, 34};
        vecs[4]  = '{32'd7,        32'd0,          32'd0,          32'd0,          1'b1, 1,  1};
        vecs[5]  = '{32'd9,        32'd3,          32'd3,          32'd0,          1'b0, 34, 34};
        vecs[6]  = '{32'h80000000, 32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 34, 34};
        vecs[7]  = '{32'h80000000, 32'd1,          32'h80000000,   32'd0,          1'b0, 34, 34};
        vecs[8]  = '{32'h7FFFFFFF, 32'h80000000,   32'd0,          32'h7FFFFFFF,   1'b0, 34, 34};
        vecs[9]  = '{32'h80000000, 32'h80000000,   32'd1,          32'd0,          1'b0, 34, 34};
        vecs[10] = '{32'd0,        32'd5,          32'd0,          32'd0,          1'b0, 34, 34};
        vecs[11] = '{32'd5,        32'd100,        32'd0,          32'd5,          1'b0, 34, 34};
        vecs[12] = '{32'hFFFFFFFF, 32'd2,          32'd0,          32'hFFFFFFFF,   1'b0, 34, 34};
        vecs[13] = '{32'hFFFFFFFF, 32'd0,          32'd0,          32'd0,          1'b1, 1,  1};

        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #12;
        check("reset quotient", bus.quotient, 32'd0);
        check("reset remainder", bus.remainder, 32'd0);
        check("reset ready", {31'd0, bus.ready}, 32'd0);
        check("reset exception", {31'd0, bus.exception}, 32'd0);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_div(vecs[i].a, vecs[i].b, lat, bcnt, bar);
            check($sformatf("v%0d latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d busy cycles", i), bcnt, vecs[i].busy_cycles);
            check($sformatf("v%0d busy at ready", i), {31'd0, bar}, 32'd0);
            check($sformatf("v%0d quotient", i), bus.quotient, vecs[i].q);
            check($sformatf("v%0d remainder", i), bus.remainder, vecs[i].r);
            check($sformatf("v%0d exception", i), {31'd0, bus.exception}, {31'd0, vecs[i].exc});
            @(posedge clock);
            #1;
            check($sformatf("v%0d ready pulse", i), {31'd0, bus.ready}, 32'd0);
            check($sformatf("v%0d quotient hold", i), bus.quotient, vecs[i].q);
            check($sformatf("v%0d exception hold", i), {31'd0, bus.exception}, {31'd0, vecs[i].exc});
        end

        // Restart: second start 10 edges into 100/7.
        @(negedge clock);
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        bus.start    = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        rdy       = 0;
        repeat (9) begin
            @(posedge clock);
            #1;
            if (bus.ready) rdy++;
        end
        @(negedge clock);
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
        bus.start    = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        lat       = -1;
        got_q     = 'x;
        got_r     = 'x;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clock);
            #1;
            if (bus.ready) begin
                rdy++;
                if (lat < 0) begin
                    lat   = i;
                    got_q = bus.quotient;
                    got_r = bus.remainder;
                end
            end
        end
        check("restart ready count", rdy, 32'd1);
        check("restart latency", lat, 32'd34);
        check("restart quotient", got_q, 32'd10);
        check("restart remainder", got_r, 32'd0);

        // Reset at cycle 20 of a divide; previous result (10) must be wiped at once.
        @(negedge clock);
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        bus.start    = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (19) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid reset quotient", bus.quotient, 32'd0);
        check("mid reset remainder", bus.remainder, 32'd0);
        check("mid reset busy", {31'd0, bus.busy}, 32'd0);
        check("mid reset ready", {31'd0, bus.ready}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        rdy     = 0;
        bcnt    = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.ready) rdy++;
            if (bus.busy) bcnt++;
        end
        check("post reset ready count", rdy, 32'd0);
        check("post reset busy count", bcnt, 32'd0);

        run_div(32'd9, 32'd3, lat, bcnt, bar);
        check("recovery latency", lat, 32'd34);
        check("recovery quotient", bus.quotient, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative 32-bit signed integer divider for the CPU execute stage. It sits downstream of the ALU operand inverter and reuses two's-complement negation (invert, then add one) to take operand magnitudes and to fix result signs. It produces one quotient bit per cycle and raises `ready` when the result is valid. The pipeline stalls on `busy`.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width. Only 32 is supported.

Ports:
- `clock`, in, 1: single clock; all state changes on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: single-cycle request; operands are sampled on the same edge.
- `dividend`, in, 32: signed two's-complement dividend.
- `divisor`, in, 32: signed two's-complement divisor.
- `quotient`, out, 32: signed quotient, truncated toward zero.
- `remainder`, out, 32: signed remainder; takes the dividend's sign.
- `ready`, out, 1: one-cycle pulse; results are valid from this cycle onward.
- `exception`, out, 1: divide-by-zero flag; valid while `ready` is high, then held.
- `busy`, out, 1: high from the edge after `start` until `ready` rises.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE, `start` high:
  - Latch `neg_q = dividend[31] ^ divisor[31]` and `neg_r = dividend[31]`.
  - Latch the unsigned magnitudes of both operands.
  - Clear the 32-bit partial remainder and set count = 0.
  - If divisor == 0, go to DONE with the zero flag set. Otherwise go to RUN.
- RUN, one restoring step per cycle:
  - Shift {partial remainder, dividend magnitude} left one bit.
  - Trial-subtract the divisor magnitude, computed as add of the inverted divisor plus 1 with a 33-bit carry.
  - If carry-out is 1, keep the difference and shift in 1. Otherwise restore and shift in 0.
  - After count == 31, go to FIX.
- FIX:
  - Negate the quotient magnitude if `neg_q`; negate the remainder magnitude if `neg_r`.
  - Register both results. Go to DONE.
- DONE:
  - Assert `ready` for exactly this cycle. Set `exception` to the zero flag. Return to IDLE.
  - Divide-by-zero result: quotient = 0, remainder = 0, `exception` = 1.
- `quotient`, `remainder` and `exception` hold their values until the next DONE or reset.
- `start` while `busy`: aborts the current operation, re-samples the operands and restarts from the IDLE-start action. No `ready` is issued for the aborted operation.
- 0x80000000 / 0xFFFFFFFF (-1): quotient = 0x80000000, remainder = 0, `exception` = 0. The unsigned magnitude 0x80000000 is representable, and its negation wraps to itself.
- Magnitude of 0x80000000 is 0x80000000 unsigned. There is no special case.

## Timing
- Reset values: `quotient` = 0, `remainder` = 0, `ready` = 0, `exception` = 0, `busy` = 0, state = IDLE, count = 0.
- Reset asserted mid-operation: abort immediately; all outputs take their reset values. There is no `ready` after release.
- Edge E samples `start`:
  - Normal divide: RUN covers edges E+1 .. E+32, FIX is E+33, and `ready` is high for the cycle following edge E+34.
  - Zero divisor: `ready` and `exception` are high for the cycle following edge E+1.
- `busy` is high from edge E until the edge at which `ready` rises. It is low while `ready` is high.
- `start` in the same cycle that `ready` is high is accepted as a new request. That `ready` pulse still completes for the previous result.

## Structure
- Shared package `div_pkg`:
  - `DIV_WIDTH` = 32
  - `DIV_STEPS` = 32
  - 2-bit state enum: IDLE = 0, RUN = 1, FIX = 2, DONE = 3
- Sub-module `twos_negate`:
  - 32-bit invert-plus-one, built on the ALU inverter and adder.
  - Three instances: operand magnitude (shared via mux), quotient fix, remainder fix.
- Trial subtract: a 33-bit add of `{1'b0, partial remainder}` with the inverted divisor magnitude plus 1.

## Test plan
- 100 / 7:
  - `ready` appears 34 edges after the `start` edge.
  - quotient = 14, remainder = 2, `exception` = 0.
  - `busy` is high for exactly 34 cycles.
- -100 / 7: quotient = 0xFFFFFFF2 (-14), remainder = 0xFFFFFFFE (-2). Also 100 / -7: quotient = -14, remainder = 2.
- 7 / 0: `ready` and `exception` = 1 after the edge following the `start` edge; quotient = 0, remainder = 0. A following 9 / 3 gives quotient = 3, remainder = 0, `exception` = 0.
- 0x80000000 / -1: quotient = 0x80000000, remainder = 0. Also 0x80000000 / 1: quotient = 0x80000000.
- Restart: start 100 / 7, then `start` with 50 / 5 at cycle 10. Exactly one `ready`, 34 edges after the second start, with quotient = 10 and remainder = 0.
- Reset: `reset_n` low at cycle 20 of a divide. Outputs are 0 immediately, and no `ready` follows release.
